// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared encodings for the multi-cycle main control FSM: state codes,
// opcodes, PC source selects, halt-cause codes and a legal-opcode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_R    = 4'b0000;
   localparam logic [3:0] OP_ADDI = 4'b0001;
   localparam logic [3:0] OP_BEQ  = 4'b0011;
   localparam logic [3:0] OP_BNE  = 4'b0100;
   localparam logic [3:0] OP_JMP  = 4'b0101;
   localparam logic [3:0] OP_LW   = 4'b0110;
   localparam logic [3:0] OP_SLTI = 4'b1010;
   localparam logic [3:0] OP_SLL  = 4'b1011;
   localparam logic [3:0] OP_SRL  = 4'b1100;
   localparam logic [3:0] OP_SW   = 4'b1101;
   localparam logic [3:0] OP_XOR  = 4'b1110;

   localparam logic [1:0] PC_SRC_INC    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   // funcCode meaning "add", used whenever the datapath only bumps the PC
   localparam logic [2:0] FUNC_ADD = 3'b001;

   function automatic logic is_legal_op(input logic [3:0] op);
      case (op)
         OP_R, OP_ADDI, OP_BEQ, OP_BNE, OP_JMP, OP_LW,
         OP_SLTI, OP_SLL, OP_SRL, OP_SW, OP_XOR: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive cycles a memory request has gone unacknowledged and
// flags a timeout on the MEM_TIMEOUT-th such cycle.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_wait         : FSM is in a waiting state (FETCH or MEM)
//   i_ack          : memory completion strobe
//   o_timeout      : this cycle is the MEM_TIMEOUT-th cycle without ack
// ---------------------------------------------------------------------------
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_wait,
   input  logic i_ack,
   output logic o_timeout
);

   // r_count holds the number of ackless cycles already spent in this wait,
   // so the current cycle is cycle r_count+1.
   localparam logic [7:0] LAST_CNT = 8'(MEM_TIMEOUT - 1);

   logic [7:0] r_count;
   logic       w_timeout;

   // An ack in the final cycle wins over the timeout.
   assign w_timeout = i_wait && !i_ack && (r_count == LAST_CNT);
   assign o_timeout = w_timeout;

   // Clearing whenever not waiting (or on ack/timeout) means the count is
   // always zero on entry to FETCH or MEM.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= 8'd0;
      end else if (!i_wait || i_ack || w_timeout) begin
         r_count <= 8'd0;
      end else begin
         r_count <= r_count + 8'd1;
      end
   end

endmodule

// File: rtl/main_control_fsm.sv
// ---------------------------------------------------------------------------
// main_control_fsm
// Multi-cycle processor control: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Memory handshake: mem_req is held high in FETCH/MEM until the cycle in
// which mem_ack is seen high; that cycle completes the access. mem_ack in
// any other state is ignored. Strobes are combinational from state/inputs.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   opcode, funct       : instruction fields from the IR
//   zero                : ALU zero flag (EXEC)
//   mem_ack             : memory completion strobe
//   mem_req, mem_we, addr_src, ir_write, pc_write, pc_src, reg_write,
//   wb_sel              : datapath controls
//   alu_op, func_code   : to ALU control
//   halted, err_code    : sticky halt flag and cause
//   state_dbg           : current state encoding
// ---------------------------------------------------------------------------
module main_control_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] opcode,
   input  logic [2:0] funct,
   input  logic       zero,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic       wb_sel,
   output logic [3:0] alu_op,
   output logic [2:0] func_code,
   output logic       halted,
   output logic [1:0] err_code,
   output logic [2:0] state_dbg
);

   state_t     r_state;
   logic [3:0] r_opcode;
   logic [2:0] r_funct;
   logic       r_halted;
   logic [1:0] r_err;

   logic       w_wait;
   logic       w_timeout;
   logic [3:0] w_op;
   logic [2:0] w_funct;

   assign w_wait = (r_state == ST_FETCH) || (r_state == ST_MEM);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_wait    (w_wait),
      .i_ack     (mem_ack),
      .o_timeout (w_timeout)
   );

   // In DECODE the fields are being captured this cycle, so present the
   // live IR value; afterwards present the captured copy.
   assign w_op    = (r_state == ST_DECODE) ? opcode : r_opcode;
   assign w_funct = (r_state == ST_DECODE) ? funct  : r_funct;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_FETCH;
         r_opcode <= 4'd0;
         r_funct  <= 3'd0;
         r_halted <= 1'b0;
         r_err    <= ERR_NONE;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (mem_ack) begin
                  r_state <= ST_DECODE;
               end else if (w_timeout) begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
                  r_err    <= ERR_TIMEOUT;
               end
            end
            ST_DECODE: begin
               r_opcode <= opcode;
               r_funct  <= funct;
               if (is_legal_op(opcode)) begin
                  r_state <= ST_EXEC;
               end else begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
                  r_err    <= ERR_ILLEGAL;
               end
            end
            ST_EXEC: begin
               case (r_opcode)
                  OP_BEQ, OP_BNE, OP_JMP: r_state <= ST_FETCH;
                  OP_LW, OP_SW:           r_state <= ST_MEM;
                  default:                r_state <= ST_WB;
               endcase
            end
            ST_MEM: begin
               if (mem_ack) begin
                  r_state <= (r_opcode == OP_LW) ? ST_WB : ST_FETCH;
               end else if (w_timeout) begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
                  r_err    <= ERR_TIMEOUT;
               end
            end
            ST_WB:   r_state <= ST_FETCH;
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_HALT;
         endcase
      end
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_src  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_SRC_INC;
      reg_write = 1'b0;
      wb_sel    = 1'b0;
      alu_op    = 4'b0000;
      func_code = FUNC_ADD;
      // rst_n gates the strobes so they drop the instant reset asserts,
      // even though FETCH (the reset state) would otherwise request memory.
      if (rst_n) begin
         if ((r_state == ST_DECODE) || (r_state == ST_EXEC) ||
             (r_state == ST_MEM) || (r_state == ST_WB)) begin
            alu_op    = w_op;
            func_code = (w_op == OP_R) ? w_funct : 3'b000;
         end
         case (r_state)
            ST_FETCH: begin
               mem_req = 1'b1;
               if (mem_ack) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
               end
            end
            ST_EXEC: begin
               if (((r_opcode == OP_BEQ) && zero) ||
                   ((r_opcode == OP_BNE) && !zero)) begin
                  pc_write = 1'b1;
                  pc_src   = PC_SRC_BRANCH;
               end else if (r_opcode == OP_JMP) begin
                  pc_write = 1'b1;
                  pc_src   = PC_SRC_JUMP;
               end
            end
            ST_MEM: begin
               mem_req  = 1'b1;
               addr_src = 1'b1;
               mem_we   = (r_opcode == OP_SW);
               wb_sel   = (r_opcode == OP_LW);
            end
            ST_WB: begin
               reg_write = 1'b1;
               wb_sel    = (r_opcode == OP_LW);
            end
            default: ;
         endcase
      end
   end

   assign halted    = r_halted;
   assign err_code  = r_err;
   assign state_dbg = r_state;

endmodule

// File: tb/tb_main_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_control_fsm
// Cycle-by-cycle check of main_control_fsm (MEM_TIMEOUT=3). Each step drives
// inputs on the falling edge, queues the expected output vector and compares
// it to the DUT outputs shortly afterwards.
// Vector: {state, mem_req, mem_we, addr_src, ir_write, pc_write, pc_src,
//          reg_write, wb_sel, alu_op, func_code, halted, err_code}
// ---------------------------------------------------------------------------
module tb_main_control_fsm;

  localparam int unsigned TO = 3;
  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2,
                         S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [2:0] funct = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, addr_src, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write, wb_sel;
  logic [3:0] alu_op;
  logic [2:0] func_code;
  logic       halted;
  logic [1:0] err_code;
  logic [2:0] state_dbg;

  int n_tests = 0;
  int n_fail = 0;
  logic [21:0] exp_q[$];
  logic [21:0] w_obs;

  always #5 clk = ~clk;

  main_control_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_src  (addr_src),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .alu_op    (alu_op),
    .func_code (func_code),
    .halted    (halted),
    .err_code  (err_code),
    .state_dbg (state_dbg)
  );

  assign w_obs = {state_dbg, mem_req, mem_we, addr_src, ir_write, pc_write,
                  pc_src, reg_write, wb_sel, alu_op, func_code, halted, err_code};

  function automatic logic [21:0] ev(
    input logic [2:0] st, input logic req, input logic we, input logic asrc,
    input logic irw, input logic pcw, input logic [1:0] pcs, input logic rw,
    input logic wbs, input logic [3:0] aop, input logic [2:0] fc,
    input logic h, input logic [1:0] err);
    return {st, req, we, asrc, irw, pcw, pcs, rw, wbs, aop, fc, h, err};
  endfunction

  function automatic logic [21:0] v_rst();
    return ev(S_F, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0, 3'b001, 0, 2'b00);
  endfunction
  function automatic logic [21:0] v_fetch(input logic ack);
    return ev(S_F, 1, 0, 0, ack, ack, 2'b00, 0, 0, 4'h0, 3'b001, 0, 2'b00);
  endfunction
  function automatic logic [21:0] v_dec(input logic [3:0] op, input logic [2:0] fc);
    return ev(S_D, 0, 0, 0, 0, 0, 2'b00, 0, 0, op, fc, 0, 2'b00);
  endfunction
  function automatic logic [21:0] v_exec(input logic [3:0] op, input logic [2:0] fc,
                                         input logic pcw, input logic [1:0] pcs);
    return ev(S_E, 0, 0, 0, 0, pcw, pcs, 0, 0, op, fc, 0, 2'b00);
  endfunction
  function automatic logic [21:0] v_mem(input logic [3:0] op, input logic we, input logic wbs);
    return ev(S_M, 1, we, 1, 0, 0, 2'b00, 0, wbs, op, 3'b000, 0, 2'b00);
  endfunction
  function automatic logic [21:0] v_wb(input logic [3:0] op, input logic [2:0] fc, input logic wbs);
    return ev(S_W, 0, 0, 0, 0, 0, 2'b00, 1, wbs, op, fc, 0, 2'b00);
  endfunction
  function automatic logic [21:0] v_halt(input logic [1:0] err);
    return ev(S_H, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0, 3'b001, 1, err);
  endfunction

  task automatic check_vec(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic ack,
                      input logic z, input logic [21:0] exp);
    @(negedge clk);
    rst_n   = rst;
    mem_ack = ack;
    zero    = z;
    exp_q.push_back(exp);
    #2;
    check_vec(tag, w_obs, exp_q.pop_front());
  endtask

  // Register-type instruction with immediate fetch ack.
  task automatic alu_instr(input string tag, input logic [3:0] op, input logic [2:0] fn);
    logic [2:0] fc;
    fc = (op == 4'b0000) ? fn : 3'b000;
    opcode = op;
    funct  = fn;
    step({tag, "_fetch"}, 1, 1, 0, v_fetch(1));
    step({tag, "_dec"},   1, 0, 0, v_dec(op, fc));
    step({tag, "_exec"},  1, 0, 0, v_exec(op, fc, 0, 2'b00));
    step({tag, "_wb"},    1, 0, 0, v_wb(op, fc, 0));
  endtask

  logic [3:0] br_op  [5] = '{4'b0011, 4'b0011, 4'b0100, 4'b0100, 4'b0101};
  logic       br_z   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       br_pcw [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] br_pcs [5] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10};

  initial begin
    // reset state
    step("reset", 0, 0, 0, v_rst());

    // addi: ack on the 3rd fetch cycle (== timeout boundary), ack ignored later
    opcode = 4'b0001;
    funct  = 3'b101;
    step("addi_f0",   1, 0, 0, v_fetch(0));
    step("addi_f1",   1, 0, 0, v_fetch(0));
    step("addi_f2",   1, 1, 0, v_fetch(1));
    step("addi_dec",  1, 1, 0, v_dec(4'b0001, 3'b000));
    step("addi_exec", 1, 1, 0, v_exec(4'b0001, 3'b000, 0, 2'b00));
    step("addi_wb",   1, 1, 0, v_wb(4'b0001, 3'b000, 0));

    alu_instr("rtype", 4'b0000, 3'b110);
    alu_instr("xor",   4'b1110, 3'b111);
    alu_instr("sll",   4'b1011, 3'b010);

    // branches and jump
    for (int i = 0; i < 5; i++) begin
      opcode = br_op[i];
      funct  = 3'($urandom_range(0, 7));
      step("br_fetch", 1, 1, 0, v_fetch(1));
      step("br_dec",   1, 0, 0, v_dec(br_op[i], 3'b000));
      step("br_exec",  1, 0, br_z[i], v_exec(br_op[i], 3'b000, br_pcw[i], br_pcs[i]));
    end

    // sw: no write-back afterwards
    opcode = 4'b1101;
    funct  = 3'b011;
    step("sw_fetch", 1, 1, 0, v_fetch(1));
    step("sw_dec",   1, 0, 0, v_dec(4'b1101, 3'b000));
    step("sw_exec",  1, 0, 0, v_exec(4'b1101, 3'b000, 0, 2'b00));
    step("sw_mem0",  1, 0, 0, v_mem(4'b1101, 1, 0));
    step("sw_mem1",  1, 1, 0, v_mem(4'b1101, 1, 0));
    step("sw_after", 1, 0, 0, v_fetch(0));

    // lw: ack on the 3rd MEM cycle wins over the timeout
    opcode = 4'b0110;
    funct  = 3'b000;
    step("lw_fetch", 1, 1, 0, v_fetch(1));
    step("lw_dec",   1, 0, 0, v_dec(4'b0110, 3'b000));
    step("lw_exec",  1, 0, 0, v_exec(4'b0110, 3'b000, 0, 2'b00));
    step("lw_mem0",  1, 0, 0, v_mem(4'b0110, 0, 1));
    step("lw_mem1",  1, 0, 0, v_mem(4'b0110, 0, 1));
    step("lw_mem2",  1, 1, 0, v_mem(4'b0110, 0, 1));
    step("lw_wb",    1, 0, 0, v_wb(4'b0110, 3'b000, 1));

    // lw interrupted by reset in MEM
    step("lwr_fetch", 1, 1, 0, v_fetch(1));
    step("lwr_dec",   1, 0, 0, v_dec(4'b0110, 3'b000));
    step("lwr_exec",  1, 0, 0, v_exec(4'b0110, 3'b000, 0, 2'b00));
    step("lwr_mem",   1, 0, 0, v_mem(4'b0110, 0, 1));
    step("lwr_rst",   0, 0, 0, v_rst());
    step("lwr_post",  1, 0, 0, v_fetch(0));

    // illegal opcode, ack pulses in HALT change nothing
    opcode = 4'b0010;
    step("ill_fetch", 1, 1, 0, v_fetch(1));
    step("ill_dec",   1, 0, 0, v_dec(4'b0010, 3'b000));
    step("ill_halt0", 1, 1, 0, v_halt(2'b01));
    step("ill_halt1", 1, 0, 0, v_halt(2'b01));
    step("ill_halt2", 1, 1, 0, v_halt(2'b01));

    // fetch timeout
    step("to_rst", 0, 0, 0, v_rst());
    opcode = 4'b0001;
    step("to_f0",   1, 0, 0, v_fetch(0));
    step("to_f1",   1, 0, 0, v_fetch(0));
    step("to_f2",   1, 0, 0, v_fetch(0));
    step("to_halt", 1, 1, 0, v_halt(2'b10));
    step("to_hold", 1, 0, 0, v_halt(2'b10));

    // MEM timeout on lw
    step("mto_rst", 0, 0, 0, v_rst());
    opcode = 4'b0110;
    step("mto_fetch", 1, 1, 0, v_fetch(1));
    step("mto_dec",   1, 0, 0, v_dec(4'b0110, 3'b000));
    step("mto_exec",  1, 0, 0, v_exec(4'b0110, 3'b000, 0, 2'b00));
    step("mto_mem0",  1, 0, 0, v_mem(4'b0110, 0, 1));
    step("mto_mem1",  1, 0, 0, v_mem(4'b0110, 0, 1));
    step("mto_mem2",  1, 0, 0, v_mem(4'b0110, 0, 1));
    step("mto_halt",  1, 1, 0, v_halt(2'b10));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
